// File: rtl/gpio_button_conditioner_pkg.sv
// Shared constants for the GPIO button input stage.
// Board pin mapping and default debounce depth live here.
package gpio_button_conditioner_pkg;

  localparam int DATA_W       = 16;
  localparam int DEBOUNCE_DEF = 16;

  localparam int BTN0_GPIO_IDX = 25;
  localparam int BTN1_GPIO_IDX = 26;
  localparam int BTN2_GPIO_IDX = 27;
  localparam int BTN3_GPIO_IDX = 28;

  typedef enum logic [1:0] {
    EVT_IDLE  = 2'd0,
    EVT_SET   = 2'd1,
    EVT_CLEAR = 2'd2
  } evt_op_e;

endpackage

// File: rtl/gpio_button_conditioner_debounce_channel.sv
// One button: 2-flop synchroniser, stability counter,
// registered rising-edge pulse on the debounced level.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             s;

  assign s = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], raw};
    cnt_d   = cnt_q;
    level_d = level_q;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = s;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    // Pulse coincides with the first cycle the new level shows 1.
    pulse_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = pulse_q;

endmodule

// File: rtl/gpio_button_conditioner.sv
// Button input stage: per-pin debounce, sticky press events
// with clear-on-read, maskable interrupt request.
module gpio_button_conditioner
  import gpio_button_conditioner_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int CNT_W           = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               rd_evt,
  input  logic               wr_mask,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [DATA_W-1:0]  irq_mask,
  output logic               irq
);

  logic [NUM_BTN-1:0] evt_q, evt_d;
  logic [DATA_W-1:0]  mask_q, mask_d;
  logic               irq_q, irq_d;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .raw        (btn_raw[i]),
      .level      (btn_level[i]),
      .rise_pulse (press_pulse[i])
    );
  end

  always_comb begin
    // A press landing on the read cycle survives the clear.
    if (rd_evt) evt_d = press_pulse;
    else        evt_d = evt_q | press_pulse;
    mask_d = wr_mask ? wdata : mask_q;
    irq_d  = |(evt_d & mask_d[NUM_BTN-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_q  <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      evt_q  <= evt_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    rdata              = '0;
    rdata[NUM_BTN-1:0] = evt_q;
  end

  assign irq_mask = mask_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_button_conditioner.sv
// Directed bench for the button conditioner, debounce depth 4.
// Expectations queued at stimulus time, checked on output.
module tb_gpio_button_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btn_raw;
  logic        rd_evt;
  logic        wr_mask;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [3:0]  btn_level;
  logic [3:0]  press_pulse;
  logic [15:0] irq_mask;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  string       tag_q[$];
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  gpio_button_conditioner #(
    .NUM_BTN         (4),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .rd_evt      (rd_evt),
    .wr_mask     (wr_mask),
    .wdata       (wdata),
    .rdata       (rdata),
    .btn_level   (btn_level),
    .press_pulse (press_pulse),
    .irq_mask    (irq_mask),
    .irq         (irq)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic want(input string t, input logic [15:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic got(input logic [15:0] o);
    string       t;
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty obs=%h exp=none", o);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      assert (o === e) else begin
        miscompares++;
        $error("FAIL %s obs=%h exp=%h", t, o, e);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    btn_raw = 4'hF;
    rd_evt  = 1'b0;
    wr_mask = 1'b0;
    wdata   = 16'h0;

    // 1: reset with all pins high
    tick(3);
    want("rst_level", 16'h0);
    want("rst_pulse", 16'h0);
    want("rst_rdata", 16'h0);
    want("rst_mask",  16'h0);
    want("rst_irq",   16'h0);
    got({12'h0, btn_level});
    got({12'h0, press_pulse});
    got(rdata);
    got(irq_mask);
    got({15'h0, irq});
    rst     = 1'b0;
    btn_raw = 4'h0;
    tick(3);

    // 2: clean press of btn0
    btn_raw = 4'h1;
    want("p0_lvl_e4",   16'h0);
    want("p0_lvl_e5",   16'h1);
    want("p0_pls_e5",   16'h1);
    want("p0_rd_e5",    16'h0);
    want("p0_pls_e6",   16'h0);
    want("p0_rd_e6",    16'h1);
    tick(5);
    got({12'h0, btn_level});
    tick(1);
    got({12'h0, btn_level});
    got({12'h0, press_pulse});
    got(rdata);
    tick(1);
    got({12'h0, press_pulse});
    got(rdata);
    tick(20);

    // release of btn0: no pulse
    btn_raw = 4'h0;
    want("r0_lvl_e4", 16'h1);
    want("r0_lvl_e5", 16'h0);
    want("r0_pls_e5", 16'h0);
    want("r0_pls_e6", 16'h0);
    tick(5);
    got({12'h0, btn_level});
    tick(1);
    got({12'h0, btn_level});
    got({12'h0, press_pulse});
    tick(1);
    got({12'h0, press_pulse});

    // 4: read-clear
    rd_evt = 1'b1;
    want("rd_during", 16'h1);
    want("rd_after",  16'h0);
    got(rdata);
    tick(1);
    rd_evt = 1'b0;
    got(rdata);

    // 3: three-cycle glitch on btn1
    btn_raw = 4'h2;
    tick(3);
    btn_raw = 4'h0;
    want("gl_lvl", 16'h0);
    want("gl_rd",  16'h0);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (press_pulse !== 4'h0) begin
        miscompares++;
        $error("FAIL gl_pulse obs=%h exp=0", press_pulse);
      end
    end
    got({12'h0, btn_level});
    got(rdata);

    // 5: read collides with btn1 press
    btn_raw = 4'h1;
    tick(7);
    btn_raw = 4'h3;
    want("col_pls", 16'h2);
    want("col_pre", 16'h1);
    want("col_post", 16'h2);
    tick(6);
    got({12'h0, press_pulse});
    rd_evt = 1'b1;
    got(rdata);
    tick(1);
    rd_evt = 1'b0;
    got(rdata);

    // 6: mask, irq
    btn_raw = 4'h0;
    rd_evt  = 1'b1;
    tick(1);
    rd_evt  = 1'b0;
    wr_mask = 1'b1;
    wdata   = 16'h0002;
    tick(1);
    wr_mask = 1'b0;
    wdata   = 16'h0;
    want("msk_val", 16'h0002);
    got(irq_mask);
    tick(8);
    want("idle_rd", 16'h0);
    got(rdata);

    btn_raw = 4'h1;
    want("b0_rd",  16'h1);
    want("b0_irq", 16'h0);
    tick(7);
    got(rdata);
    got({15'h0, irq});

    btn_raw = 4'h3;
    want("b1_irq_e5", 16'h0);
    want("b1_rd_e6",  16'h3);
    want("b1_irq_e6", 16'h1);
    tick(6);
    got({15'h0, irq});
    tick(1);
    got(rdata);
    got({15'h0, irq});

    // reset with btn2's counter at 2
    btn_raw = 4'h7;
    tick(4);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    want("mr_level", 16'h0);
    want("mr_rdata", 16'h0);
    want("mr_mask",  16'h0);
    want("mr_irq",   16'h0);
    got({12'h0, btn_level});
    got(rdata);
    got(irq_mask);
    got({15'h0, irq});
    want("mr_lvl_e4", 16'h0);
    want("mr_lvl_e5", 16'h7);
    want("mr_pls_e5", 16'h7);
    tick(5);
    got({12'h0, btn_level});
    tick(1);
    got({12'h0, btn_level});
    got({12'h0, press_pulse});

    if (exp_q.size() != 0) begin
      miscompares++;
      $error("FAIL sb_leftover obs=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_button_conditioner.md
Name: gpio_button_conditioner

Overview:
Input stage between the raw board GPIO button pins and the CPU's memory-mapped I/O in top. Per button it synchronises, debounces, detects the press edge, and latches press events into a sticky 16-bit event register. The CPU reads this register and clears it on read. A maskable interrupt-request level is raised while any enabled event is pending.

Parameters:
NUM_BTN, 4, number of button inputs conditioned (1..16)
DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles required before the debounced level changes (>=1)
CNT_W, 8, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous, active-high reset
btn_raw  input  NUM_BTN  asynchronous button pins, active-high (e.g. gpio1[25])
rd_evt  input  1  CPU read strobe for the event register, one cycle
wr_mask  input  1  CPU write strobe for the interrupt mask
wdata  input  16  mask write data
rdata  output  16  current event register, zero-extended above NUM_BTN
btn_level  output  NUM_BTN  debounced button level
press_pulse  output  NUM_BTN  one-cycle pulse on a debounced rising edge
irq_mask  output  16  current mask register
irq  output  1  OR of (event & mask)

Behaviour:
- One clock and one reset. Reset is synchronous and active-high; the port names are clk and rst.
- Reset values: sync flops, counters, btn_level, press_pulse, event register, irq_mask, irq all 0. Reset mid-count discards any partial debounce.
- Synchroniser: each btn_raw bit passes through 2 flops to give s. There is no other path from btn_raw.
- Debounce counter, per bit, on each edge:
  - s == btn_level: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: btn_level <= s, cnt <= 0.
  - else: cnt <= cnt+1.
- Latency: a clean raw change first sampled at edge E0 makes btn_level change after edge E(DEBOUNCE_CYCLES+1).
- Glitch rejection: a deviation of s lasting fewer than DEBOUNCE_CYCLES cycles restarts the count and never changes btn_level. Release is debounced identically.
- press_pulse: registered. It is high for exactly the one cycle in which btn_level is first observed 1 after being 0. It never fires on release.
- Event register, bits [NUM_BTN-1:0]:
  - A bit is set by press_pulse.
  - On rd_evt, rdata presents the pre-clear value combinationally that cycle, and the bits read are cleared at the edge.
  - A press_pulse in the same cycle as rd_evt wins: that bit is set after the edge.
  - Bits >= NUM_BTN always read 0.
- Mask: on wr_mask, irq_mask <= wdata at the edge. Bits >= NUM_BTN are stored but have no effect.
- irq: registered. irq <= |(next_event & irq_mask[NUM_BTN-1:0]), so it updates in the same edge as the event or mask change.
- rd_evt and wr_mask in the same cycle are independent and both take effect.
- Multiple simultaneous presses each set their own bit.

Decomposition:
- Shared package: DATA_W=16 constant, default DEBOUNCE_CYCLES, and the GPIO bit index of each button (BTN0_GPIO_IDX=25, etc.) used by top.
- One natural sub-module: debounce_channel. It is a single-bit synchroniser plus counter plus edge detector with outputs level and rise_pulse, instantiated NUM_BTN times in a generate loop.
- The event, mask and irq logic stays in gpio_button_conditioner.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with btn_raw=4'hF -> btn_level=0, press_pulse=0, rdata=16'h0000, irq_mask=0, irq=0.
2. Clean press, DEBOUNCE_CYCLES=4: btn_raw[0] 0->1 before edge E0, held 50 cycles -> btn_level[0]=1 after E5, press_pulse[0]=1 for exactly one cycle, rdata=16'h0001. Release -> btn_level[0]=0 after 6 edges, no press_pulse.
3. Glitch, DEBOUNCE_CYCLES=4: btn_raw[1] high for 3 cycles then low -> btn_level[1] stays 0, press_pulse stays 0, rdata stays 16'h0000.
4. Read-clear: with event=16'h0001, pulse rd_evt -> rdata=16'h0001 during the strobe, 16'h0000 the next cycle.
5. Read/press collision: event=16'h0001, rd_evt coincides with press_pulse[1] -> after the edge rdata=16'h0002, not 0.
6. Mask/irq and reset mid-operation:
   - wr_mask wdata=16'h0002, then press btn0 -> irq=0.
   - Press btn1 -> irq=1 on the edge its event bit sets.
   - Assert rst while btn2's counter is at 2 -> all outputs 0, and btn2 needs a full DEBOUNCE_CYCLES+2 edges after rst deasserts.
